// File: rtl/request_responder_pkg.sv
// request_responder_pkg: shared state encoding and limits for the
// request/accept/cancel responder.
package request_responder_pkg;

   // Smallest legal request-to-accept latency; the initiator side relies
   // on accept staying low for at least this many cycles after request.
   localparam int MIN_ACCEPT_DELAY = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCEPT = 2'd2,
      BUSY   = 2'd3
   } state_e;

endpackage

// File: rtl/request_responder.sv
// request_responder: target end of the request/accept/cancel handshake.
// A request pulse is answered with a one-cycle accept ACCEPT_DELAY cycles
// later (unless cancelled), followed by a BUSY_CYCLES-long busy window
// with done flagging its last cycle. Requests that cannot be taken are
// reported on dropped and never queued.
// Optional embedded assertions: define REQUEST_RESPONDER_SVA_EN.
module request_responder
   import request_responder_pkg::*;
#(
   parameter int ACCEPT_DELAY = 4,
   parameter int BUSY_CYCLES  = 8,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic request,
   input  logic cancel,
   output logic accept,
   output logic busy,
   output logic done,
   output logic dropped
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // Counter reload values; WAIT counts ACCEPT_DELAY-2 .. 0 so that the
   // accept register is set at the end of cycle ACCEPT_DELAY-1.
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ACCEPT_DELAY - 2);
   localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Reject illegal parameterisations at elaboration
   generate
      if (ACCEPT_DELAY < MIN_ACCEPT_DELAY) begin : g_err_delay_min
         $error("request_responder: ACCEPT_DELAY below MIN_ACCEPT_DELAY");
      end
      if (BUSY_CYCLES == 0) begin : g_err_busy_zero
         $error("request_responder: BUSY_CYCLES must be nonzero");
      end
      if (ACCEPT_DELAY > CNT_MAX || BUSY_CYCLES > CNT_MAX) begin : g_err_cnt_w
         $error("request_responder: CNT_W too narrow for the latencies");
      end
   endgenerate

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_accept;
   logic             r_busy;
   logic             r_done;
   logic             r_dropped;

   // FSM with shared down-counter; all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_accept  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_accept  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         // Any request outside IDLE is discarded and reported
         r_dropped <= request && (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (request) begin
                  if (cancel) begin
                     r_dropped <= 1'b1;
                  end else begin
                     r_state <= WAIT;
                     r_cnt   <= WAIT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cancel) begin
                  r_state <= IDLE;
               end else if (r_cnt == '0) begin
                  r_state  <= ACCEPT;
                  r_accept <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
               end
            end
            ACCEPT: begin
               // A cancel coinciding with accept still aborts the service
               if (cancel) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= BUSY;
                  r_cnt   <= BUSY_LOAD;
                  r_busy  <= 1'b1;
                  r_done  <= (BUSY_CYCLES == 1);
               end
            end
            BUSY: begin
               // cancel has no effect once service has started
               if (r_cnt == '0) begin
                  r_state <= IDLE;
               end else begin
                  r_cnt  <= r_cnt - CNT_ONE;
                  r_busy <= 1'b1;
                  r_done <= (r_cnt == CNT_ONE);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign accept  = r_accept;
   assign busy    = r_busy;
   assign done    = r_done;
   assign dropped = r_dropped;

`ifdef REQUEST_RESPONDER_SVA_EN
   default clocking cb_sva @(posedge clk);
   endclocking
   default disable iff (!rst_n);

   a_no_early_accept: assert property (request |-> !accept [*4]);
   a_busy_after_accept: assert property ($rose(busy) |-> $past(accept && !cancel));
   a_accept_pulse: assert property (accept |=> !accept);
   a_busy_length: assert property ($rose(busy) |-> busy [*BUSY_CYCLES] ##1 !busy);
   c_full_trace: cover property (
      (request && !cancel) ##1 (!accept) [*1:$] ##1 (accept && !cancel)
      ##1 busy [*1:$] ##0 done);
`endif

endmodule

// File: tb/tb_request_responder.sv
// tb_request_responder: directed self-checking bench for request_responder.
// One instance with default parameters, one with ACCEPT_DELAY=6,
// BUSY_CYCLES=1. Cycle 0 of each scenario is the cycle the first request
// is driven; outputs are checked 1 time unit after each rising edge.
module tb_request_responder;

   logic clk = 1'b0;
   logic rst_n, request, cancel;
   logic accept, busy, done, dropped;
   logic rst_n2, request2, cancel2;
   logic accept2, busy2, done2, dropped2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   request_responder dut (
      .clk(clk), .rst_n(rst_n), .request(request), .cancel(cancel),
      .accept(accept), .busy(busy), .done(done), .dropped(dropped)
   );

   request_responder #(.ACCEPT_DELAY(6), .BUSY_CYCLES(1), .CNT_W(8)) dut2 (
      .clk(clk), .rst_n(rst_n2), .request(request2), .cancel(cancel2),
      .accept(accept2), .busy(busy2), .done(done2), .dropped(dropped2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int c, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
      end
   endtask

   task automatic check4(input string tag, input int c,
                         input logic ea, input logic eb, input logic ed, input logic edr);
      check({tag, ".accept"},  c, accept,  ea);
      check({tag, ".busy"},    c, busy,    eb);
      check({tag, ".done"},    c, done,    ed);
      check({tag, ".dropped"}, c, dropped, edr);
   endtask

   initial begin
      // ---------------- reset ----------------
      rst_n = 1'b0; request = 1'b0; cancel = 1'b0;
      rst_n2 = 1'b0; request2 = 1'b0; cancel2 = 1'b0;
      step(); step();
      check4("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset2.accept", 0, accept2, 1'b0);
      check("reset2.busy",   0, busy2,   1'b0);
      rst_n = 1'b1; rst_n2 = 1'b1;
      step();

      // ---------------- request + cancel in IDLE: dropped only ----------------
      for (int c = 0; c <= 6; c++) begin
         request = (c == 0); cancel = (c == 0);
         check4("idle_reqcan", c, 1'b0, 1'b0, 1'b0, c == 1);
         step();
      end

      // ---------------- basic: accept 4, busy 5..12, done 12 ----------------
      for (int c = 0; c <= 14; c++) begin
         request = (c == 0); cancel = 1'b0;
         check4("basic", c, c == 4, c >= 5 && c <= 12, c == 12, 1'b0);
         step();
      end

      // ---------------- cancel in WAIT, re-request in cycle 3 ----------------
      for (int c = 0; c <= 17; c++) begin
         request = (c == 0) || (c == 3); cancel = (c == 2);
         check4("cancel_wait", c, c == 7, c >= 8 && c <= 15, c == 15, 1'b0);
         step();
      end

      // ---------------- cancel together with accept ----------------
      for (int c = 0; c <= 14; c++) begin
         request = (c == 0); cancel = (c == 4);
         check4("cancel_acc", c, c == 4, 1'b0, 1'b0, 1'b0);
         step();
      end

      // ---------------- extra requests dropped ----------------
      for (int c = 0; c <= 14; c++) begin
         request = (c == 0) || (c == 2) || (c == 8); cancel = 1'b0;
         check4("dropped", c, c == 4, c >= 5 && c <= 12, c == 12, c == 3 || c == 9);
         step();
      end

      // ---------------- reset during busy, then fresh request ----------------
      for (int c = 0; c <= 22; c++) begin
         request = (c == 0) || (c == 8); cancel = 1'b0; rst_n = (c != 6);
         check4("mid_reset", c, c == 4 || c == 12,
                (c >= 5 && c <= 6) || (c >= 13 && c <= 20), c == 20, 1'b0);
         step();
      end
      rst_n = 1'b1; request = 1'b0;

      // ---------------- ACCEPT_DELAY=6, BUSY_CYCLES=1 ----------------
      for (int c = 0; c <= 9; c++) begin
         request2 = (c == 0); cancel2 = 1'b0;
         check("p6_1.accept",  c, accept2,  c == 6);
         check("p6_1.busy",    c, busy2,    c == 7);
         check("p6_1.done",    c, done2,    c == 7);
         check("p6_1.dropped", c, dropped2, 1'b0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
